// File: rtl/circuito_exp_6.sv
// Colour-sequence memory game core: datapath, control FSM, play timer and 7-seg debug.
// Runs on a 1 kHz clock, so every cycle constant below is in milliseconds.

module hex7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);
    logic anterior;

    // registered pulse: one cycle after the rising edge, once per press
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anterior <= 1'b0;
            pulso    <= 1'b0;
        end else begin
            anterior <= sinal;
            pulso    <= sinal & ~anterior;
        end
    end
endmodule

module circuito_exp_6 (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [3:0] botoes,
    input  logic [1:0] configuracao,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic       timeout,
    output logic [2:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada,
    output logic       db_timeout,
    output logic       db_fimRodada,
    output logic       db_zeraCL
);
    localparam logic [13:0] T_EXIBE   = 14'd2000;
    localparam logic [13:0] T_TIMEOUT = 14'd10000;

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARACAO       = 4'h1,
        EXIBE_INICIAL    = 4'h2,
        INICIA_RODADA    = 4'h3,
        ESPERA_JOGADA    = 4'h4,
        REGISTRA         = 4'h5,
        COMPARA          = 4'h6,
        PROXIMA_JOGADA   = 4'h7,
        ESPERA_ADICIONAL = 4'h8,
        GRAVA            = 4'h9,
        PROXIMA_RODADA   = 4'hA,
        FINAL_ACERTOU    = 4'hC,
        FINAL_TIMEOUT    = 4'hD,
        FINAL_ERROU      = 4'hE
    } estado_t;

    estado_t     state;
    logic [3:0]  endereco;
    logic [3:0]  rodada;
    logic [13:0] timer;
    logic [3:0]  jogada;
    logic        modo_r;
    logic        tmo_en_r;
    logic        tem_jogada;
    logic [3:0]  mem [16];
    logic [3:0]  mem_dado;
    logic        igual;
    logic        fim_rodada;
    logic        fim_timer;
    logic [3:0]  ultima;
    logic [3:0]  estado_cod;

    edge_detector u_edge (
        .clock (clock),
        .reset (reset),
        .sinal (|botoes),
        .pulso (tem_jogada)
    );

    // Word 0 is the fixed opening colour; appended plays land at E >= 1, so it is never written.
    always_ff @(posedge clock) begin
        if (state == GRAVA && endereco != 4'd0)
            mem[endereco] <= botoes;
    end

    assign mem_dado   = (endereco == 4'd0) ? 4'b0001 : mem[endereco];
    assign igual      = (jogada == mem_dado);
    assign fim_rodada = (endereco == rodada);
    assign fim_timer  = (timer == T_TIMEOUT - 14'd1);
    assign ultima     = modo_r ? 4'd3 : 4'd15;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= INICIAL;
            endereco <= 4'd0;
            rodada   <= 4'd0;
            timer    <= 14'd0;
            jogada   <= 4'd0;
            modo_r   <= 1'b0;
            tmo_en_r <= 1'b0;
        end else begin
            case (state)
                INICIAL:
                    if (jogar) state <= PREPARACAO;
                PREPARACAO: begin
                    endereco <= 4'd0;
                    rodada   <= 4'd0;
                    timer    <= 14'd0;
                    modo_r   <= configuracao[0];
                    tmo_en_r <= configuracao[1];
                    state    <= EXIBE_INICIAL;
                end
                EXIBE_INICIAL:
                    if (timer == T_EXIBE - 14'd1) begin
                        timer <= 14'd0;
                        state <= INICIA_RODADA;
                    end else begin
                        timer <= timer + 14'd1;
                    end
                INICIA_RODADA: begin
                    endereco <= 4'd0;
                    timer    <= 14'd0;
                    state    <= ESPERA_JOGADA;
                end
                ESPERA_JOGADA: begin
                    // a press in the terminal cycle beats the timeout
                    if (tem_jogada)                 state <= REGISTRA;
                    else if (tmo_en_r && fim_timer) state <= FINAL_TIMEOUT;
                    if (!fim_timer) timer <= timer + 14'd1;
                end
                REGISTRA: begin
                    jogada <= botoes;
                    state  <= COMPARA;
                end
                COMPARA:
                    if (!igual) begin
                        state <= FINAL_ERROU;
                    end else if (fim_rodada) begin
                        endereco <= endereco + 4'd1;
                        timer    <= 14'd0;
                        state    <= ESPERA_ADICIONAL;
                    end else begin
                        state <= PROXIMA_JOGADA;
                    end
                PROXIMA_JOGADA: begin
                    endereco <= endereco + 4'd1;
                    timer    <= 14'd0;
                    state    <= ESPERA_JOGADA;
                end
                ESPERA_ADICIONAL: begin
                    if (tem_jogada)                 state <= GRAVA;
                    else if (tmo_en_r && fim_timer) state <= FINAL_TIMEOUT;
                    if (!fim_timer) timer <= timer + 14'd1;
                end
                GRAVA:
                    state <= PROXIMA_RODADA;
                PROXIMA_RODADA:
                    if (rodada == ultima) begin
                        state <= FINAL_ACERTOU;
                    end else begin
                        rodada <= rodada + 4'd1;
                        state  <= INICIA_RODADA;
                    end
                FINAL_ACERTOU, FINAL_TIMEOUT, FINAL_ERROU:
                    if (jogar) state <= PREPARACAO;
                default:
                    state <= INICIAL;
            endcase
        end
    end

    function automatic logic [1:0] indice(input logic [3:0] v);
        case (v)
            4'b0010: indice = 2'd1;
            4'b0100: indice = 2'd2;
            4'b1000: indice = 2'd3;
            default: indice = 2'd0;
        endcase
    endfunction

    always_comb begin
        leds = 3'b000;
        if (state == EXIBE_INICIAL)
            leds = {1'b1, indice(mem_dado)};
        else if (state != INICIAL && |botoes)
            leds = {1'b1, indice(botoes)};
    end

    assign ganhou  = (state == FINAL_ACERTOU);
    assign timeout = (state == FINAL_TIMEOUT);
    assign perdeu  = (state == FINAL_TIMEOUT) || (state == FINAL_ERROU);
    assign pronto  = ganhou || perdeu;

    assign estado_cod = state;

    logic [3:0][3:0] hex_in;
    logic [3:0][6:0] hex_out;

    assign hex_in = {endereco, mem_dado, estado_cod, jogada};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_hex
            hex7seg u_hex (.hex(hex_in[g]), .seg(hex_out[g]));
        end
    endgenerate

    assign db_contagem    = hex_out[3];
    assign db_memoria     = hex_out[2];
    assign db_estado      = hex_out[1];
    assign db_jogadafeita = hex_out[0];

    assign db_igual      = igual;
    assign db_clock      = clock;
    assign db_iniciar    = jogar;
    assign db_tem_jogada = tem_jogada;
    assign db_timeout    = fim_timer;
    assign db_fimRodada  = fim_rodada;
    assign db_zeraCL     = (state == PREPARACAO) || (state == INICIA_RODADA);
endmodule

// File: tb/tb_circuito_exp_6.sv
// Directed bench for circuito_exp_6: vector table for start-up and the first play,
// then hand sequences for a full demo game, a wrong play, timeout and reset.

module tb_circuito_exp_6;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic [3:0] botoes = 4'd0;
    logic [1:0] configuracao = 2'd0;
    logic       ganhou, perdeu, pronto, timeout;
    logic [2:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
    logic       db_clock, db_iniciar, db_tem_jogada, db_timeout, db_fimRodada, db_zeraCL;

    circuito_exp_6 dut (
        .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
        .configuracao(configuracao),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
        .leds(leds), .db_igual(db_igual),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_clock(db_clock), .db_iniciar(db_iniciar),
        .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
        .db_fimRodada(db_fimRodada), .db_zeraCL(db_zeraCL)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       jg;
        logic [3:0] bt;
        logic [1:0] cfg;
        int         cycles;
        logic [3:0] estado;
        logic [2:0] leds;
        logic [3:0] flags;   // {ganhou, perdeu, pronto, timeout}
        logic [3:0] cont;
        logic       chk_igual;
        logic       igual;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
            4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
            4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
            4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_game(input string name, input logic [3:0] estado, input logic [3:0] flags);
        check({name, "_estado"}, {25'd0, db_estado}, {25'd0, seg(estado)});
        check({name, "_flags"}, {28'd0, ganhou, perdeu, pronto, timeout}, {28'd0, flags});
    endtask

    task automatic press(input logic [3:0] b);
        botoes = b;
        repeat (20) @(posedge clock);
        #1;
        botoes = 4'd0;
        repeat (10) @(posedge clock);
        #1;
    endtask

    task automatic start_game(input logic [1:0] cfg);
        configuracao = cfg;
        jogar = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        jogar = 1'b0;
    endtask

    task automatic wait_estado(input string name, input logic [3:0] estado, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (db_estado === seg(estado)) found = 1'b1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: state %0h not reached in %0d cycles (seg now %0h)", name, estado, budget, db_estado);
        end
    endtask

    logic [3:0] seq [5];
    int n;

    initial begin
        //            rst jg  bt       cfg    cyc   est   leds    flags    cont igc ig
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 2'b01, 2,    4'h0, 3'b000, 4'b0000, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 2'b01, 3,    4'h0, 3'b000, 4'b0000, 4'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'b0000, 2'b01, 1,    4'h1, 3'b000, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'b0000, 2'b01, 1,    4'h2, 3'b100, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'b0000, 2'b01, 1000, 4'h2, 3'b100, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'b0000, 2'b01, 999,  4'h2, 3'b100, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'b0000, 2'b01, 1,    4'h3, 3'b000, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'b0000, 2'b01, 1,    4'h4, 3'b000, 4'b0000, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'b0001, 2'b01, 1,    4'h4, 3'b100, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'b0001, 2'b01, 1,    4'h5, 3'b100, 4'b0000, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'b0001, 2'b01, 1,    4'h6, 3'b100, 4'b0000, 4'd0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'b0001, 2'b01, 1,    4'h8, 3'b100, 4'b0000, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'b0001, 2'b01, 16,   4'h8, 3'b100, 4'b0000, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'b0000, 2'b01, 10,   4'h8, 3'b000, 4'b0000, 4'd1, 1'b0, 1'b0};

        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

        #1;
        for (int i = 0; i < 14; i++) begin
            reset        = vecs[i].rst_n;
            jogar        = vecs[i].jg;
            botoes       = vecs[i].bt;
            configuracao = vecs[i].cfg;
            repeat (vecs[i].cycles) @(posedge clock);
            #1;
            check_game($sformatf("row%0d", i), vecs[i].estado, vecs[i].flags);
            check($sformatf("row%0d_leds", i), {29'd0, leds}, {29'd0, vecs[i].leds});
            check($sformatf("row%0d_cont", i), {25'd0, db_contagem}, {25'd0, seg(vecs[i].cont)});
            if (vecs[i].chk_igual)
                check($sformatf("row%0d_igual", i), {31'd0, db_igual}, {31'd0, vecs[i].igual});
        end

        // finish round 1 of the demo game, then rounds 2..4
        press(seq[1]);
        check_game("r1_append", 4'h4, 4'b0000);
        check("r1_append_cont", {25'd0, db_contagem}, {25'd0, seg(4'd0)});
        for (int r = 1; r < 4; r++) begin
            for (int i = 0; i <= r; i++) begin
                press(seq[i]);
                check_game($sformatf("r%0d_rep%0d", r + 1, i), (i == r) ? 4'h8 : 4'h4, 4'b0000);
            end
            press(seq[r + 1]);
            check_game($sformatf("r%0d_append", r + 1), (r == 3) ? 4'hC : 4'h4,
                       (r == 3) ? 4'b1010 : 4'b0000);
        end

        // restart from the win state, then miss the first play of round 2
        start_game(2'b01);
        check_game("restart", 4'h2, 4'b0000);
        check("restart_leds", {29'd0, leds}, {29'd0, 3'b100});
        wait_estado("errou_wait", 4'h4, 2100);
        press(4'b0001);
        press(4'b0010);
        press(4'b1000);
        check_game("errou", 4'hE, 4'b0110);
        check("errou_jogada", {25'd0, db_jogadafeita}, {25'd0, seg(4'h8)});

        // timeout enabled: no append play after round 1
        start_game(2'b11);
        check("tmo_leds", {29'd0, leds}, {29'd0, 3'b100});
        wait_estado("tmo_wait", 4'h4, 2100);
        press(4'b0001);
        n = 30;
        while (timeout !== 1'b1 && n < 10300) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n < 10002 || n > 10006) begin
            failures++;
            $display("FAIL tmo_latency: got %0d cycles expected 10002..10006", n);
        end
        check_game("tmo_final", 4'hD, 4'b0111);

        // timeout disabled: waits indefinitely in espera_adicional
        start_game(2'b01);
        wait_estado("notmo_wait", 4'h4, 2100);
        press(4'b0001);
        repeat (20000) @(posedge clock);
        #1;
        check_game("notmo", 4'h8, 4'b0000);

        // asynchronous reset in the middle of a round
        #2;
        reset = 1'b0;
        #1;
        check_game("async_rst", 4'h0, 4'b0000);
        check("async_rst_leds", {29'd0, leds}, {29'd0, 3'b000});
        check("async_rst_cont", {25'd0, db_contagem}, {25'd0, seg(4'd0)});
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_game("post_rst_idle", 4'h0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
